// File: rtl/mem_arb_pkg.sv
// Shared types and default parameters for the memory port arbiter.
// Imported by the interface, the starvation counter and the arbiter top.
package mem_arb_pkg;

    localparam int ADDR_W_DEF         = 10;
    localparam int DATA_W_DEF         = 16;
    localparam int FETCH_MAX_WAIT_DEF = 4;

    // Each state names the access being driven onto the memory port this cycle.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        IF_ACC = 2'd1,
        D_ACC  = 2'd2
    } arb_state_e;

    function automatic int starve_cnt_w(input int max_wait);
        return (max_wait < 1) ? 1 : $clog2(max_wait + 1);
    endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bundle of the fetch port, data port and shared memory port signals.
// The arbiter uses the slave modport; the requesters and the memory use master.
interface mem_port_arbiter_if
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) ();

    logic              if_req;
    logic [ADDR_W-1:0] if_adr;
    logic              if_gnt;
    logic              if_valid;
    logic [DATA_W-1:0] if_rdata;

    logic              d_req;
    logic              d_we;
    logic [ADDR_W-1:0] d_adr;
    logic [DATA_W-1:0] d_wdata;
    logic              d_gnt;
    logic              d_valid;
    logic [DATA_W-1:0] d_rdata;

    logic [ADDR_W-1:0] m_adr;
    logic [DATA_W-1:0] m_wdata;
    logic              m_read;
    logic              m_write;
    logic [DATA_W-1:0] m_rdata;

    modport slave (
        input  if_req, if_adr, d_req, d_we, d_adr, d_wdata, m_rdata,
        output if_gnt, if_valid, if_rdata, d_gnt, d_valid, d_rdata,
        output m_adr, m_wdata, m_read, m_write
    );

    modport master (
        output if_req, if_adr, d_req, d_we, d_adr, d_wdata, m_rdata,
        input  if_gnt, if_valid, if_rdata, d_gnt, d_valid, d_rdata,
        input  m_adr, m_wdata, m_read, m_write
    );

endinterface

// File: rtl/fetch_starve_ctr.sv
// Counts consecutive cycles in which a pending fetch was denied the memory port.
// Saturates at MAX_WAIT so the arbiter can force the fetch through.
module fetch_starve_ctr
    import mem_arb_pkg::*;
#(
    parameter int MAX_WAIT = FETCH_MAX_WAIT_DEF,
    parameter int CNT_W    = starve_cnt_w(FETCH_MAX_WAIT_DEF)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_if_req,
    input  logic             i_if_gnt,
    output logic [CNT_W-1:0] o_count
);

    logic [CNT_W-1:0] r_count;

    // Denied-fetch counter: grows while fetch waits, clears on grant or no request.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (i_if_req && !i_if_gnt) begin
            if (r_count != CNT_W'(MAX_WAIT)) begin
                r_count <= r_count + CNT_W'(1);
            end else begin
                r_count <= r_count;
            end
        end else begin
            r_count <= '0;
        end
    end

    assign o_count = r_count;

endmodule

// File: rtl/mem_port_arbiter.sv
// Two-requester arbiter for a single-port memory: data has priority, fetch is
// forced through after FETCH_MAX_WAIT denials. Grant N, access N+1, valid N+2.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int FETCH_MAX_WAIT = FETCH_MAX_WAIT_DEF,
    parameter int ADDR_W         = ADDR_W_DEF,
    parameter int DATA_W         = DATA_W_DEF
) (
    input  logic                clk,
    input  logic                rst_n,
    mem_port_arbiter_if.slave   bus
);

    localparam int CNT_W = starve_cnt_w(FETCH_MAX_WAIT);

    arb_state_e        r_state;
    arb_state_e        w_next_state;
    logic [CNT_W-1:0]  w_starve_cnt;
    logic              w_fetch_forced;
    logic              w_if_win;
    logic              w_d_win;

    logic [ADDR_W-1:0] r_adr;
    logic [DATA_W-1:0] r_wdata;
    logic              r_m_read;
    logic              r_m_write;
    logic              r_if_valid;
    logic              r_d_valid;
    logic [DATA_W-1:0] r_if_rdata;
    logic [DATA_W-1:0] r_d_rdata;

    fetch_starve_ctr #(
        .MAX_WAIT (FETCH_MAX_WAIT),
        .CNT_W    (CNT_W)
    ) u_starve (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_if_req (bus.if_req),
        .i_if_gnt (w_if_win),
        .o_count  (w_starve_cnt)
    );

    // Arbitration and next-state selection; runs every cycle so grants can be back to back.
    always_comb begin
        w_fetch_forced = bus.if_req && (w_starve_cnt == CNT_W'(FETCH_MAX_WAIT));
        w_if_win       = 1'b0;
        w_d_win        = 1'b0;
        w_next_state   = IDLE;
        case (r_state)
            IDLE, IF_ACC, D_ACC: begin
                if (w_fetch_forced) begin
                    w_if_win     = 1'b1;
                    w_next_state = IF_ACC;
                end else if (bus.d_req) begin
                    w_d_win      = 1'b1;
                    w_next_state = D_ACC;
                end else if (bus.if_req) begin
                    w_if_win     = 1'b1;
                    w_next_state = IF_ACC;
                end else begin
                    w_next_state = IDLE;
                end
            end
            default: begin
                w_if_win     = 1'b0;
                w_d_win      = 1'b0;
                w_next_state = IDLE;
            end
        endcase
    end

    // Grants are masked by reset so nothing is accepted while rst_n is low.
    assign bus.if_gnt = w_if_win & rst_n;
    assign bus.d_gnt  = w_d_win & rst_n;

    // State register and capture of the winner's request into the memory port.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_adr     <= '0;
            r_wdata   <= '0;
            r_m_read  <= 1'b0;
            r_m_write <= 1'b0;
        end else begin
            r_state   <= w_next_state;
            r_m_read  <= w_if_win | (w_d_win & ~bus.d_we);
            r_m_write <= w_d_win & bus.d_we;
            if (w_d_win) begin
                r_adr   <= bus.d_adr;
                r_wdata <= bus.d_wdata;
            end else if (w_if_win) begin
                r_adr   <= bus.if_adr;
                r_wdata <= r_wdata;
            end else begin
                r_adr   <= r_adr;
                r_wdata <= r_wdata;
            end
        end
    end

    // Response stage: valid one cycle after the access; rdata holds between reads.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_if_valid <= 1'b0;
            r_d_valid  <= 1'b0;
            r_if_rdata <= '0;
            r_d_rdata  <= '0;
        end else begin
            r_if_valid <= (r_state == IF_ACC);
            r_d_valid  <= (r_state == D_ACC);
            if (r_state == IF_ACC) begin
                r_if_rdata <= bus.m_rdata;
            end else begin
                r_if_rdata <= r_if_rdata;
            end
            if ((r_state == D_ACC) && r_m_read) begin
                r_d_rdata <= bus.m_rdata;
            end else begin
                r_d_rdata <= r_d_rdata;
            end
        end
    end

    assign bus.m_adr    = r_adr;
    assign bus.m_wdata  = r_wdata;
    assign bus.m_read   = r_m_read;
    assign bus.m_write  = r_m_write;
    assign bus.if_valid = r_if_valid;
    assign bus.if_rdata = r_if_rdata;
    assign bus.d_valid  = r_d_valid;
    assign bus.d_rdata  = r_d_rdata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a behavioural single-port memory.
module tb_mem_port_arbiter;
    import mem_arb_pkg::*;

    logic clk;
    logic rst_n;
    int   n_tests;
    int   n_fail;

    logic [15:0] mem     [0:1023];
    bit          written [0:1023];

    mem_port_arbiter_if #(.ADDR_W(10), .DATA_W(16)) bus ();

    mem_port_arbiter #(
        .FETCH_MAX_WAIT (4),
        .ADDR_W         (10),
        .DATA_W         (16)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Unwritten words read as 0xA800 | address, except word 500 which reads 1.
    assign bus.m_rdata = written[bus.m_adr] ? mem[bus.m_adr] :
                         ((bus.m_adr == 10'd500) ? 16'h0001 : (16'hA800 | {6'd0, bus.m_adr}));

    always @(posedge clk) begin
        if (bus.m_write) begin
            mem[bus.m_adr]     <= bus.m_wdata;
            written[bus.m_adr] <= 1'b1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        rst_n = 1'b0;
        bus.if_req = 1'b0; bus.if_adr = 10'd0;
        bus.d_req = 1'b0; bus.d_we = 1'b0; bus.d_adr = 10'd0; bus.d_wdata = 16'h0000;

        // Reset values
        #2;
        chk("rst_m_read",   32'(bus.m_read),   32'd0);
        chk("rst_m_write",  32'(bus.m_write),  32'd0);
        chk("rst_m_adr",    32'(bus.m_adr),    32'd0);
        chk("rst_m_wdata",  32'(bus.m_wdata),  32'd0);
        chk("rst_if_valid", 32'(bus.if_valid), 32'd0);
        chk("rst_d_valid",  32'(bus.d_valid),  32'd0);
        chk("rst_if_rdata", 32'(bus.if_rdata), 32'd0);
        chk("rst_d_rdata",  32'(bus.d_rdata),  32'd0);
        chk("rst_state",    32'(dut.r_state),  32'(IDLE));
        bus.d_req = 1'b1;
        bus.if_req = 1'b1;
        #1;
        chk("rst_d_gnt",  32'(bus.d_gnt),  32'd0);
        chk("rst_if_gnt", 32'(bus.if_gnt), 32'd0);
        bus.d_req = 1'b0;
        bus.if_req = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Data read of address 500 in the first cycle after reset
        bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_adr = 10'd500;
        #1;
        chk("a_d_gnt",  32'(bus.d_gnt),  32'd1);
        chk("a_if_gnt", 32'(bus.if_gnt), 32'd0);
        tick();
        bus.d_req = 1'b0;
        chk("a_m_read",  32'(bus.m_read),  32'd1);
        chk("a_m_write", 32'(bus.m_write), 32'd0);
        chk("a_m_adr",   32'(bus.m_adr),   32'd500);
        chk("a_valid_early", 32'(bus.d_valid), 32'd0);
        tick();
        chk("a_d_valid", 32'(bus.d_valid), 32'd1);
        chk("a_d_rdata", 32'(bus.d_rdata), 32'h0001);
        tick();
        chk("a_valid_drop", 32'(bus.d_valid), 32'd0);
        chk("a_rdata_hold", 32'(bus.d_rdata), 32'h0001);

        // Simultaneous write (data) and fetch to address 20
        bus.if_req = 1'b1; bus.if_adr = 10'd20;
        bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_adr = 10'd20; bus.d_wdata = 16'hABCD;
        #1;
        chk("b_d_gnt",  32'(bus.d_gnt),  32'd1);
        chk("b_if_gnt0", 32'(bus.if_gnt), 32'd0);
        tick();
        bus.d_req = 1'b0; bus.d_we = 1'b0;
        #1;
        chk("b_if_gnt1", 32'(bus.if_gnt), 32'd1);
        chk("b_m_write", 32'(bus.m_write), 32'd1);
        chk("b_m_read0", 32'(bus.m_read),  32'd0);
        chk("b_m_adr",   32'(bus.m_adr),   32'd20);
        chk("b_m_wdata", 32'(bus.m_wdata), 32'hABCD);
        tick();
        bus.if_req = 1'b0;
        chk("b_m_read1",   32'(bus.m_read),  32'd1);
        chk("b_d_valid_w", 32'(bus.d_valid), 32'd1);
        chk("b_d_rdata_w", 32'(bus.d_rdata), 32'h0001);
        tick();
        chk("b_if_valid", 32'(bus.if_valid), 32'd1);
        chk("b_if_rdata", 32'(bus.if_rdata), 32'hABCD);
        tick();

        // Starvation: data held 10 cycles, fetch forced on the 5th
        bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_adr = 10'd3;
        bus.if_req = 1'b1; bus.if_adr = 10'd9;
        for (int c = 1; c <= 10; c++) begin
            #1;
            chk($sformatf("c_if_gnt_%0d", c), 32'(bus.if_gnt), (c == 5) ? 32'd1 : 32'd0);
            chk($sformatf("c_d_gnt_%0d", c),  32'(bus.d_gnt),  (c == 5) ? 32'd0 : 32'd1);
            tick();
            if (c == 5) bus.if_req = 1'b0;
        end
        bus.d_req = 1'b0;
        tick();
        tick();

        // Back-to-back fetches of addresses 0,1,2
        bus.if_req = 1'b1; bus.if_adr = 10'd0;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk($sformatf("d_if_gnt_%0d", k), 32'(bus.if_gnt), 32'd1);
            if (k == 2) begin
                chk("d_if_valid_0", 32'(bus.if_valid), 32'd1);
                chk("d_if_rdata_0", 32'(bus.if_rdata), 32'hA800);
            end
            tick();
            bus.if_adr = 10'(k + 1);
        end
        bus.if_req = 1'b0;
        chk("d_if_valid_1", 32'(bus.if_valid), 32'd1);
        chk("d_if_rdata_1", 32'(bus.if_rdata), 32'hA801);
        tick();
        chk("d_if_valid_2", 32'(bus.if_valid), 32'd1);
        chk("d_if_rdata_2", 32'(bus.if_rdata), 32'hA802);
        tick();
        chk("d_if_valid_end", 32'(bus.if_valid), 32'd0);
        chk("d_if_rdata_hold", 32'(bus.if_rdata), 32'hA802);

        // Idle for 5 cycles
        repeat (5) tick();
        chk("e_state",    32'(dut.r_state),  32'(IDLE));
        chk("e_m_read",   32'(bus.m_read),   32'd0);
        chk("e_m_write",  32'(bus.m_write),  32'd0);
        chk("e_if_valid", 32'(bus.if_valid), 32'd0);
        chk("e_d_valid",  32'(bus.d_valid),  32'd0);

        // Reset asserted mid-write to address 7
        bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_adr = 10'd7; bus.d_wdata = 16'h1234;
        tick();
        bus.d_req = 1'b0; bus.d_we = 1'b0;
        chk("f_m_write_on", 32'(bus.m_write), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("f_m_write_off", 32'(bus.m_write), 32'd0);
        chk("f_m_read_off",  32'(bus.m_read),  32'd0);
        tick();
        tick();
        chk("f_d_valid", 32'(bus.d_valid), 32'd0);
        chk("f_d_rdata", 32'(bus.d_rdata), 32'd0);
        chk("f_mem7_written", 32'(written[7]), 32'd0);
        rst_n = 1'b1;
        bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_adr = 10'd7;
        #1;
        chk("f_first_gnt", 32'(bus.d_gnt), 32'd1);
        tick();
        bus.d_req = 1'b0;
        tick();
        chk("f_rd_valid", 32'(bus.d_valid), 32'd1);
        chk("f_rd_mem7",  32'(bus.d_rdata), 32'hA807);
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
